// File: rtl/pipe_decode_unit.sv
// pipe_decode_unit
// Instruction buffer plus a decode stage for an RV32I(+M) front end. Fetched
// words go into a circular FIFO. The head word is decoded combinationally and
// captured into a registered output stage, which drains with a valid/ready
// handshake.
//
// Ports
//   CLK, RST             clock, synchronous active-high reset
//   in_valid/in_ready    fetch handshake; in_instr/in_pc carry the word and its PC
//   flush                squash buffered and output-stage words
//   out_valid/out_ready  consumer handshake for the decoded word
//   out_pc, out_instr    PC and raw word (funct3 is read from out_instr for M ops)
//   out_rd/rs1/rs2       register fields
//   out_aluop            0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA,
//                        8 SLT, 9 SLTU
//   out_* controls       alusrc, memwrite, memtoreg, regwen, pctoreg, branch,
//                        halt, illegal, muldiv, jump[2:0]
//   halted               sticky; set once a halt word leaves the output stage
//   count                number of words held in the FIFO
// The halt instruction uses the otherwise unused opcode 7'b1111111.
module pipe_decode_unit #(
    parameter int DEPTH = 4,
    parameter int MEXT  = 0
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic [31:0]                in_pc,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_instr,
    output logic [4:0]                 out_rd,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [3:0]                 out_aluop,
    output logic                       out_alusrc,
    output logic                       out_memwrite,
    output logic                       out_memtoreg,
    output logic                       out_regwen,
    output logic                       out_pctoreg,
    output logic                       out_branch,
    output logic                       out_halt,
    output logic                       out_illegal,
    output logic                       out_muldiv,
    output logic [2:0]                 out_jump,
    output logic                       halted,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_BTYPE = 7'b1100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_HALT  = 7'b1111111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    // ALU op for the funct3 encodings shared by register and immediate forms.
    function automatic logic [3:0] base_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  base_alu = ALU_ADD;
            3'b001:  base_alu = ALU_SLL;
            3'b010:  base_alu = ALU_SLT;
            3'b011:  base_alu = ALU_SLTU;
            3'b100:  base_alu = ALU_XOR;
            3'b101:  base_alu = ALU_SRL;
            3'b110:  base_alu = ALU_OR;
            3'b111:  base_alu = ALU_AND;
            default: base_alu = ALU_ADD;
        endcase
    endfunction

    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   pc_mem_q    [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          halt_seen_q, halted_q, out_valid_q;

    logic full_s, empty_s, push_s, load_s, out_xfer_s;
    logic [31:0] head_instr_s, head_pc_s;
    logic [6:0]  opc_s, f7_s;
    logic [2:0]  f3_s;

    logic [3:0] dec_aluop_s;
    logic [2:0] dec_jump_s;
    logic dec_alusrc_s, dec_memwrite_s, dec_memtoreg_s, dec_regwen_s;
    logic dec_pctoreg_s, dec_branch_s, dec_halt_s, dec_illegal_s, dec_muldiv_s;

    logic [31:0] out_pc_q, out_instr_q;
    logic [3:0]  out_aluop_q;
    logic [2:0]  out_jump_q;
    logic out_alusrc_q, out_memwrite_q, out_memtoreg_q, out_regwen_q;
    logic out_pctoreg_q, out_branch_q, out_halt_q, out_illegal_q, out_muldiv_q;

    assign full_s       = (count_q == CW'(DEPTH));
    assign empty_s      = (count_q == {CW{1'b0}});
    assign in_ready     = !full_s && !halt_seen_q && !flush;
    assign push_s       = in_valid && in_ready;
    // Flush wins over loading the output stage.
    assign load_s       = !empty_s && (!out_valid_q || out_ready) && !flush;
    assign out_xfer_s   = out_valid_q && out_ready;
    assign head_instr_s = instr_mem_q[rptr_q];
    assign head_pc_s    = pc_mem_q[rptr_q];
    assign opc_s        = head_instr_s[6:0];
    assign f3_s         = head_instr_s[14:12];
    assign f7_s         = head_instr_s[31:25];

    // Combinational decode of the FIFO head; illegal words keep all
    // write/jump/branch controls at their defaults.
    always_comb begin
        dec_aluop_s    = ALU_ADD;
        dec_jump_s     = 3'b000;
        dec_alusrc_s   = 1'b0;
        dec_memwrite_s = 1'b0;
        dec_memtoreg_s = 1'b0;
        dec_regwen_s   = 1'b0;
        dec_pctoreg_s  = 1'b0;
        dec_branch_s   = 1'b0;
        dec_halt_s     = 1'b0;
        dec_illegal_s  = 1'b0;
        dec_muldiv_s   = 1'b0;
        case (opc_s)
            OPC_RTYPE: begin
                if (f7_s == F7_BASE) begin
                    dec_regwen_s = 1'b1;
                    dec_aluop_s  = base_alu(f3_s);
                end else if ((f7_s == F7_ALT) && (f3_s == 3'b000)) begin
                    dec_regwen_s = 1'b1;
                    dec_aluop_s  = ALU_SUB;
                end else if ((f7_s == F7_ALT) && (f3_s == 3'b101)) begin
                    dec_regwen_s = 1'b1;
                    dec_aluop_s  = ALU_SRA;
                end else if ((f7_s == F7_MUL) && (MEXT != 32'sd0)) begin
                    dec_regwen_s = 1'b1;
                    dec_muldiv_s = 1'b1;
                end else begin
                    dec_illegal_s = 1'b1;
                end
            end
            OPC_ITYPE: begin
                dec_regwen_s = 1'b1;
                dec_alusrc_s = 1'b1;
                // Shift-right immediates: only a zero funct7 means logical.
                if (f3_s == 3'b101) begin
                    dec_aluop_s = (f7_s == F7_BASE) ? ALU_SRL : ALU_SRA;
                end else begin
                    dec_aluop_s = base_alu(f3_s);
                end
            end
            OPC_LOAD: begin
                dec_regwen_s   = 1'b1;
                dec_memtoreg_s = 1'b1;
                dec_alusrc_s   = 1'b1;
            end
            OPC_STORE: begin
                dec_memwrite_s = 1'b1;
                dec_alusrc_s   = 1'b1;
            end
            OPC_LUI: begin
                dec_regwen_s = 1'b1;
                dec_alusrc_s = 1'b1;
            end
            OPC_AUIPC: begin
                dec_regwen_s  = 1'b1;
                dec_alusrc_s  = 1'b1;
                dec_pctoreg_s = 1'b1;
            end
            OPC_BTYPE: begin
                case (f3_s)
                    3'b000:  begin dec_jump_s = 3'b001; dec_aluop_s = ALU_SUB; end
                    3'b001:  begin dec_jump_s = 3'b001; dec_aluop_s = ALU_SUB; dec_branch_s = 1'b1; end
                    3'b100:  begin dec_jump_s = 3'b001; dec_aluop_s = ALU_SLT; dec_branch_s = 1'b1; end
                    3'b101:  begin dec_jump_s = 3'b001; dec_aluop_s = ALU_SLT; end
                    3'b110:  begin dec_jump_s = 3'b001; dec_aluop_s = ALU_SLTU; dec_branch_s = 1'b1; end
                    3'b111:  begin dec_jump_s = 3'b001; dec_aluop_s = ALU_SLTU; end
                    default: dec_illegal_s = 1'b1;
                endcase
            end
            OPC_JAL: begin
                dec_jump_s    = 3'b010;
                dec_regwen_s  = 1'b1;
                dec_pctoreg_s = 1'b1;
            end
            OPC_JALR: begin
                dec_jump_s    = 3'b011;
                dec_regwen_s  = 1'b1;
                dec_pctoreg_s = 1'b1;
                dec_alusrc_s  = 1'b1;
            end
            OPC_HALT: dec_halt_s = 1'b1;
            default:  dec_illegal_s = 1'b1;
        endcase
    end

    // Occupancy after this cycle's push and pop (flush/reset handled in the register).
    always_comb begin
        if (push_s && !load_s) begin
            count_d = count_q + CW'(1);
        end else if (!push_s && load_s) begin
            count_d = count_q - CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            instr_mem_q[wptr_q] <= in_instr;
            pc_mem_q[wptr_q]    <= in_pc;
        end
    end

    // Pointers, occupancy, handshake state and the sticky halt flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr_q      <= {PW{1'b0}};
            rptr_q      <= {PW{1'b0}};
            count_q     <= {CW{1'b0}};
            halt_seen_q <= 1'b0;
            halted_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            wptr_q      <= {PW{1'b0}};
            rptr_q      <= {PW{1'b0}};
            count_q     <= {CW{1'b0}};
            halt_seen_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push_s) begin
                wptr_q <= wptr_q + PW'(1);
                if (in_instr[6:0] == OPC_HALT) begin
                    halt_seen_q <= 1'b1;
                end
            end
            if (load_s) begin
                rptr_q      <= rptr_q + PW'(1);
                out_valid_q <= 1'b1;
            end else if (out_xfer_s) begin
                out_valid_q <= 1'b0;
            end
            if (out_xfer_s && out_halt_q) begin
                halted_q <= 1'b1;
            end
        end
    end

    // Output stage: capture the decoded head on load, otherwise hold.
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_pc_q       <= 32'h0000_0000;
            out_instr_q    <= 32'h0000_0000;
            out_aluop_q    <= 4'd0;
            out_jump_q     <= 3'b000;
            out_alusrc_q   <= 1'b0;
            out_memwrite_q <= 1'b0;
            out_memtoreg_q <= 1'b0;
            out_regwen_q   <= 1'b0;
            out_pctoreg_q  <= 1'b0;
            out_branch_q   <= 1'b0;
            out_halt_q     <= 1'b0;
            out_illegal_q  <= 1'b0;
            out_muldiv_q   <= 1'b0;
        end else if (load_s) begin
            out_pc_q       <= head_pc_s;
            out_instr_q    <= head_instr_s;
            out_aluop_q    <= dec_aluop_s;
            out_jump_q     <= dec_jump_s;
            out_alusrc_q   <= dec_alusrc_s;
            out_memwrite_q <= dec_memwrite_s;
            out_memtoreg_q <= dec_memtoreg_s;
            out_regwen_q   <= dec_regwen_s;
            out_pctoreg_q  <= dec_pctoreg_s;
            out_branch_q   <= dec_branch_s;
            out_halt_q     <= dec_halt_s;
            out_illegal_q  <= dec_illegal_s;
            out_muldiv_q   <= dec_muldiv_s;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_pc       = out_pc_q;
    assign out_instr    = out_instr_q;
    assign out_rd       = out_instr_q[11:7];
    assign out_rs1      = out_instr_q[19:15];
    assign out_rs2      = out_instr_q[24:20];
    assign out_aluop    = out_aluop_q;
    assign out_jump     = out_jump_q;
    assign out_alusrc   = out_alusrc_q;
    assign out_memwrite = out_memwrite_q;
    assign out_memtoreg = out_memtoreg_q;
    assign out_regwen   = out_regwen_q;
    assign out_pctoreg  = out_pctoreg_q;
    assign out_branch   = out_branch_q;
    assign out_halt     = out_halt_q;
    assign out_illegal  = out_illegal_q;
    assign out_muldiv   = out_muldiv_q;
    assign halted       = halted_q;
    assign count        = count_q;
endmodule

// File: tb/tb_pipe_decode_unit.sv
// Bench for pipe_decode_unit: two instances (MEXT=0 and MEXT=1) share one
// stimulus stream; a queue-based model predicts every output each cycle.
module tb_pipe_decode_unit;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3, A_XOR = 4'd4;
    localparam logic [3:0] A_SLL = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7, A_SLT = 4'd8, A_SLTU = 4'd9;

    logic CLK, RST, in_valid, flush, out_ready;
    logic [31:0] in_instr, in_pc;
    logic [1:0] in_rdy, o_valid, o_src, o_mw, o_m2r, o_wen, o_p2r, o_br, o_halt, o_ill, o_md, o_halted;
    logic [1:0][31:0] o_pc, o_instr;
    logic [1:0][4:0] o_rd, o_rs1, o_rs2;
    logic [1:0][3:0] o_alu;
    logic [1:0][2:0] o_jump;
    logic [1:0][CW-1:0] o_cnt;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        pipe_decode_unit #(.DEPTH(DEPTH), .MEXT(g)) u_dut (
            .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_rdy[g]),
            .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
            .out_valid(o_valid[g]), .out_ready(out_ready),
            .out_pc(o_pc[g]), .out_instr(o_instr[g]),
            .out_rd(o_rd[g]), .out_rs1(o_rs1[g]), .out_rs2(o_rs2[g]),
            .out_aluop(o_alu[g]), .out_alusrc(o_src[g]), .out_memwrite(o_mw[g]),
            .out_memtoreg(o_m2r[g]), .out_regwen(o_wen[g]), .out_pctoreg(o_p2r[g]),
            .out_branch(o_br[g]), .out_halt(o_halt[g]), .out_illegal(o_ill[g]),
            .out_muldiv(o_md[g]), .out_jump(o_jump[g]),
            .halted(o_halted[g]), .count(o_cnt[g])
        );
    end

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] m_q[$];
    bit m_ov, m_hs, m_halted, m_zero;
    logic [31:0] m_oi, m_opc;

    function automatic logic [3:0] f3_alu(input logic [2:0] f3);
        logic [3:0] tbl [8];
        tbl = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
        return tbl[f3];
    endfunction

    // {aluop, jump, alusrc, memwrite, memtoreg, regwen, pctoreg, branch, halt, illegal, muldiv}
    function automatic logic [15:0] mdl_ctrl(input logic [31:0] w, input int mext);
        logic [3:0] alu;
        logic [2:0] jmp, f3;
        logic [6:0] f7;
        logic src, mw, m2r, wen, p2r, br, hlt, ill, md;
        f3 = w[14:12];
        f7 = w[31:25];
        alu = A_ADD;
        jmp = 3'd0;
        {src, mw, m2r, wen, p2r, br, hlt, ill, md} = 9'd0;
        case (w[6:0])
            7'h33: begin
                if (f7 == 7'h00) begin wen = 1'b1; alu = f3_alu(f3); end
                else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
                    wen = 1'b1; alu = (f3 == 3'd0) ? A_SUB : A_SRA;
                end
                else if (f7 == 7'h01 && mext == 1) begin wen = 1'b1; md = 1'b1; end
                else ill = 1'b1;
            end
            7'h13: begin wen = 1'b1; src = 1'b1; alu = (f3 == 3'd5 && f7 != 7'h00) ? A_SRA : f3_alu(f3); end
            7'h03: {wen, m2r, src} = 3'b111;
            7'h23: {mw, src} = 2'b11;
            7'h37: {wen, src} = 2'b11;
            7'h17: {wen, src, p2r} = 3'b111;
            7'h63: begin
                if (f3 == 3'd2 || f3 == 3'd3) ill = 1'b1;
                else begin
                    jmp = 3'd1;
                    alu = (f3 < 3'd2) ? A_SUB : (f3 < 3'd6) ? A_SLT : A_SLTU;
                    br  = (f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd6);
                end
            end
            7'h6F: begin jmp = 3'd2; wen = 1'b1; p2r = 1'b1; end
            7'h67: begin jmp = 3'd3; wen = 1'b1; p2r = 1'b1; src = 1'b1; end
            7'h7F: hlt = 1'b1;
            default: ill = 1'b1;
        endcase
        return {alu, jmp, src, mw, m2r, wen, p2r, br, hlt, ill, md};
    endfunction

    function automatic logic [94:0] exp_vec(input int g);
        if (m_zero) return 95'd0;
        return {m_opc, m_oi, m_oi[11:7], m_oi[19:15], m_oi[24:20], mdl_ctrl(m_oi, g)};
    endfunction

    function automatic logic [94:0] act_vec(input int g);
        return {o_pc[g], o_instr[g], o_rd[g], o_rs1[g], o_rs2[g], o_alu[g], o_jump[g],
                o_src[g], o_mw[g], o_m2r[g], o_wen[g], o_p2r[g], o_br[g], o_halt[g], o_ill[g], o_md[g]};
    endfunction

    task automatic model_edge();
        bit acc, xfer, ld;
        logic [63:0] e;
        if (RST) begin
            m_q.delete(); m_ov = 0; m_hs = 0; m_halted = 0; m_zero = 1; m_oi = '0; m_opc = '0;
        end else if (flush) begin
            m_q.delete(); m_ov = 0; m_hs = 0;
        end else begin
            acc  = in_valid && (m_q.size() < DEPTH) && !m_hs;
            xfer = m_ov && out_ready;
            ld   = (m_q.size() > 0) && (!m_ov || out_ready);
            if (xfer && m_oi[6:0] == 7'h7F) m_halted = 1;
            if (ld) begin
                e = m_q.pop_front();
                m_oi = e[63:32]; m_opc = e[31:0]; m_ov = 1; m_zero = 0;
            end else if (xfer) begin
                m_ov = 0;
            end
            if (acc) begin
                m_q.push_back({in_instr, in_pc});
                if (in_instr[6:0] == 7'h7F) m_hs = 1;
            end
        end
    endtask

    // Compare process: every output of both instances, every cycle after the first reset.
    always @(negedge CLK) begin
        if (chk_en) begin
            for (int g = 0; g < 2; g++) begin
                chk($sformatf("in_ready[%0d]", g), 96'(in_rdy[g]),
                    96'((m_q.size() < DEPTH) && !m_hs && !flush));
                chk($sformatf("out_valid[%0d]", g), 96'(o_valid[g]), 96'(m_ov));
                chk($sformatf("count[%0d]", g), 96'(o_cnt[g]), 96'(m_q.size()));
                chk($sformatf("halted[%0d]", g), 96'(o_halted[g]), 96'(m_halted));
                chk($sformatf("data[%0d]", g), 96'(act_vec(g)), 96'(exp_vec(g)));
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
        model_edge();
    endtask

    task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] pc,
                         input logic rdy, input logic fl);
        in_valid = v; in_instr = w; in_pc = pc; out_ready = rdy; flush = fl;
    endtask

    function automatic logic [31:0] gen_word();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 15))
            0, 1, 2: begin
                w[6:0] = 7'h33;
                case ($urandom_range(0, 3))
                    0: w[31:25] = 7'h00;
                    1: w[31:25] = 7'h20;
                    2: w[31:25] = 7'h01;
                    default: ;
                endcase
            end
            3, 4: begin
                w[6:0] = 7'h13;
                if ($urandom_range(0, 1) == 0) w[31:25] = 7'h00;
            end
            5: w[6:0] = 7'h03;
            6: w[6:0] = 7'h23;
            7: w[6:0] = 7'h37;
            8: w[6:0] = 7'h17;
            9, 10: w[6:0] = 7'h63;
            11: w[6:0] = 7'h6F;
            12: w[6:0] = 7'h67;
            13: w = ($urandom_range(0, 3) == 0) ? 32'h0000_007F : 32'h0020_81B3;
            14: ;
            default: w = 32'h0220_81B3;
        endcase
        return w;
    endfunction

    initial begin
        RST = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        step();
        chk_en = 1'b1;
        chk("rst_count", 96'(o_cnt[0]), 96'd0);
        chk("rst_valid", 96'(o_valid[0]), 96'd0);
        chk("rst_data", 96'(act_vec(1)), 96'd0);
        RST = 1'b0;

        // ADD x3,x1,x2: accepted at edge 1, valid after edge 2
        drive(1'b1, 32'h0020_81B3, 32'h100, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        chk("add_valid", 96'(o_valid[0]), 96'd1);
        chk("add_aluop", 96'(o_alu[0]), 96'(A_ADD));
        chk("add_regwen", 96'(o_wen[0]), 96'd1);
        chk("add_regs", 96'({o_rd[0], o_rs1[0], o_rs2[0]}), 96'({5'd3, 5'd1, 5'd2}));
        step();
        step();

        // backpressure: FIFO fills to DEPTH with one word in the output stage
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h0000_0093 | (32'(i) << 7), 32'h200 + 32'(4 * i), 1'b0, 1'b0);
            step();
        end
        chk("bp_count", 96'(o_cnt[0]), 96'd4);
        chk("bp_inready", 96'(in_rdy[0]), 96'd0);
        chk("bp_head_pc", 96'(o_pc[0]), 96'h200);
        drive(1'b1, 32'h0050_0093, 32'h214, 1'b0, 1'b0);
        step();
        chk("bp_held", 96'(o_cnt[0]), 96'd4);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        chk("bp_order", 96'(o_pc[0]), 96'h204);
        for (int i = 0; i < 6; i++) step();

        // BLTU, HALT, then ADDI which must never be accepted
        drive(1'b1, 32'h0020_E063, 32'h300, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'h0000_007F, 32'h304, 1'b1, 1'b0);
        step();
        chk("bltu_ctrl", 96'({o_jump[0], o_br[0], o_alu[0]}), 96'({3'd1, 1'b1, A_SLTU}));
        drive(1'b1, 32'h0010_0093, 32'h308, 1'b1, 1'b0);
        chk("halt_block", 96'(in_rdy[0]), 96'd0);
        step();
        chk("halt_out", 96'(o_halt[0]), 96'd1);
        step();
        chk("halted", 96'(o_halted), 96'd3);
        step();
        chk("addi_dropped", 96'({o_valid[0], o_cnt[0]}), 96'd0);

        // flush with 3 buffered and a word in the output stage
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h0000_0033 | (32'(i) << 7), 32'h500 + 32'(4 * i), 1'b0, 1'b0);
            step();
        end
        chk("pre_flush", 96'({o_cnt[0], o_valid[0]}), 96'({3'd3, 1'b1}));
        drive(1'b1, 32'h0000_0013, 32'h600, 1'b0, 1'b1);
        step();
        chk("flush_state", 96'({o_cnt[0], o_valid[0], o_halted[0]}), 96'({3'd0, 1'b0, 1'b1}));
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        chk("flush_drop", 96'({o_cnt[0], o_valid[0]}), 96'd0);

        // MUL with and without the M extension
        drive(1'b1, 32'h0220_81B3, 32'h400, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        chk("mul_m0", 96'({o_ill[0], o_wen[0], o_md[0]}), 96'({1'b1, 1'b0, 1'b0}));
        chk("mul_m1", 96'({o_ill[1], o_wen[1], o_md[1]}), 96'({1'b0, 1'b1, 1'b1}));

        // unknown opcode
        drive(1'b1, 32'h0000_000B, 32'h404, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        chk("unk_ctrl", 96'({o_valid[0], o_ill[0], o_jump[0], o_wen[0], o_mw[0], o_br[0], o_p2r[0]}),
            96'({1'b1, 1'b1, 3'd0, 4'd0}));

        // mid-stream reset with a full buffer
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h0000_0003 | (32'(i) << 7), 32'h700 + 32'(4 * i), 1'b0, 1'b0);
            step();
        end
        chk("full_count", 96'(o_cnt[0]), 96'd4);
        RST = 1'b1;
        step();
        RST = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("mid_rst", 96'({o_cnt[0], o_valid[0], o_halted[0]}), 96'd0);
        chk("mid_rst_ready", 96'(in_rdy[0]), 96'd1);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            RST       = ($urandom_range(0, 599) == 0);
            flush     = ($urandom_range(0, 39) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_instr  = gen_word();
            in_pc     = $urandom;
            step();
        end
        RST = 1'b0;
        @(negedge CLK);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
